// File: rtl/zacore_decode_sb.sv
// zacore_decode_sb: RV32I/E decode with register file, pending scoreboard and output flop stage
module zacore_decode_sb #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter bit BYPASS_WB = 1'b1,
  localparam int RIDX_W = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [31:0]       i_inst,
  input  logic [XLEN-1:0]   i_pc,
  output logic              o_stall,
  input  logic              i_stall,
  input  logic              i_invalidate,
  input  logic              i_wb_valid,
  input  logic [RIDX_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_valid,
  output logic [XLEN-1:0]   o_pc,
  output logic [2:0]        o_inst_type,
  output logic [6:0]        o_opcode,
  output logic [2:0]        o_funct3,
  output logic [6:0]        o_funct7,
  output logic [RIDX_W-1:0] o_rd,
  output logic [XLEN-1:0]   o_rs1_val,
  output logic [XLEN-1:0]   o_rs2_val,
  output logic [XLEN-1:0]   o_imm,
  output logic              o_illegal
);
  logic [6:0] op;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic is_u, is_j, is_i, is_b, is_s, is_r, known, use_rs1, use_rs2, wr_f, bad_idx, illegal, wr_rd;
  logic [2:0] typ;
  logic [31:0] imm32;
  logic [RIDX_W-1:0] rd_i, rs1_i, rs2_i;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic hit1, hit2, hitd, hazard, out_busy, issue;
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic valid_q, ill_q;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [2:0] typ_q, f3_q;
  logic [6:0] op_q, f7_q;
  logic [RIDX_W-1:0] rd_q;
  assign op = i_inst[6:0];
  assign rd_f = i_inst[11:7];
  assign rs1_f = i_inst[19:15];
  assign rs2_f = i_inst[24:20];
  assign is_u = op == 7'b0110111 || op == 7'b0010111;
  assign is_j = op == 7'b1101111;
  assign is_i = op == 7'b1100111 || op == 7'b0000011 || op == 7'b0010011 || op == 7'b0001111 || op == 7'b1110011;
  assign is_b = op == 7'b1100011;
  assign is_s = op == 7'b0100011;
  assign is_r = op == 7'b0110011;
  assign known = is_u | is_j | is_i | is_b | is_s | is_r;
  assign typ = is_u ? 3'd4 : is_j ? 3'd5 : is_i ? 3'd1 : is_b ? 3'd3 : is_s ? 3'd2 : 3'd0;
  assign use_rs1 = is_r | is_i | is_s | is_b;
  assign use_rs2 = is_r | is_s | is_b;
  assign wr_f = (is_r | is_i | is_u | is_j) && rd_f != 5'd0;
  // RV32E: any register field actually used must fit the smaller file
  assign bad_idx = (wr_f && int'(rd_f) >= NUM_REGS) || (use_rs1 && int'(rs1_f) >= NUM_REGS)
                || (use_rs2 && int'(rs2_f) >= NUM_REGS);
  assign illegal = ~known | bad_idx;
  assign wr_rd = wr_f & ~illegal;
  assign rd_i = wr_rd ? rd_f[RIDX_W-1:0] : '0;
  assign rs1_i = rs1_f[RIDX_W-1:0];
  assign rs2_i = rs2_f[RIDX_W-1:0];
  assign imm32 = is_i ? {{20{i_inst[31]}}, i_inst[31:20]}
               : is_s ? {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]}
               : is_b ? {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}
               : is_u ? {i_inst[31:12], 12'b0}
               : is_j ? {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}
               : 32'd0;
  assign hit1 = BYPASS_WB && i_wb_valid && i_wb_rd == rs1_i;
  assign hit2 = BYPASS_WB && i_wb_valid && i_wb_rd == rs2_i;
  assign hitd = BYPASS_WB && i_wb_valid && i_wb_rd == rd_i;
  assign rs1_val = rs1_i == '0 ? '0 : hit1 ? i_wb_data : rf_q[rs1_i];
  assign rs2_val = rs2_i == '0 ? '0 : hit2 ? i_wb_data : rf_q[rs2_i];
  // A register being written back this cycle is no longer a hazard when forwarded
  assign hazard = ~illegal & ((use_rs1 & pend_q[rs1_i] & ~hit1) | (use_rs2 & pend_q[rs2_i] & ~hit2)
                | (pend_q[rd_i] & ~hitd));
  assign out_busy = valid_q & i_stall;
  assign issue = i_valid & ~hazard & ~out_busy & ~i_invalidate;
  assign o_stall = i_valid & (hazard | out_busy) & ~i_invalidate;
  always_comb begin
    pend_d = (pend_q & ~(i_wb_valid ? NUM_REGS'(1) << i_wb_rd : '0)
           & ~(i_invalidate & valid_q ? NUM_REGS'(1) << rd_q : '0))
           | (issue & wr_rd ? NUM_REGS'(1) << rd_i : '0);
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_q <= '0;
      for (int k = 0; k < NUM_REGS; k++) rf_q[k] <= '0;
    end else begin
      pend_q <= pend_d;
      if (i_wb_valid && i_wb_rd != '0) rf_q[i_wb_rd] <= i_wb_data;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      ill_q <= 1'b0;
      pc_q <= '0;
      typ_q <= '0;
      op_q <= '0;
      f3_q <= '0;
      f7_q <= '0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
    end else if (i_invalidate) begin
      valid_q <= 1'b0;
    end else if (!out_busy) begin
      valid_q <= issue;
      if (issue) begin
        ill_q <= illegal;
        pc_q <= i_pc;
        typ_q <= typ;
        op_q <= op;
        f3_q <= i_inst[14:12];
        f7_q <= i_inst[31:25];
        rd_q <= rd_i;
        rs1_q <= rs1_val;
        rs2_q <= rs2_val;
        imm_q <= XLEN'($signed(imm32));
      end
    end
  end
  assign o_valid = valid_q;
  assign o_pc = pc_q;
  assign o_inst_type = typ_q;
  assign o_opcode = op_q;
  assign o_funct3 = f3_q;
  assign o_funct7 = f7_q;
  assign o_rd = rd_q;
  assign o_rs1_val = rs1_q;
  assign o_rs2_val = rs2_q;
  assign o_imm = imm_q;
  assign o_illegal = ill_q;
endmodule

// File: tb/tb_zacore_decode_sb.sv
// tb_zacore_decode_sb: directed checks of decode, scoreboard stalls, output stage and RV32E legality
module tb_zacore_decode_sb;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, stall_in = 1'b0, inval = 1'b0, wb_valid = 1'b0;
  logic [31:0] inst = '0, pc = '0, wb_data = '0;
  logic [4:0] wb_rd = '0;
  logic o_stall, o_valid, o_illegal;
  logic [31:0] o_pc, o_rs1_val, o_rs2_val, o_imm;
  logic [2:0] o_type, o_funct3;
  logic [6:0] o_opcode, o_funct7;
  logic [4:0] o_rd;
  logic s16, v16, ill16;
  logic [31:0] pc16, rs1_16, rs2_16, imm16;
  logic [2:0] type16, f3_16;
  logic [6:0] op16, f7_16;
  logic [3:0] rd16;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  zacore_decode_sb dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_inst(inst), .i_pc(pc), .o_stall(o_stall),
    .i_stall(stall_in), .i_invalidate(inval), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
    .i_wb_data(wb_data), .o_valid(o_valid), .o_pc(o_pc), .o_inst_type(o_type),
    .o_opcode(o_opcode), .o_funct3(o_funct3), .o_funct7(o_funct7), .o_rd(o_rd),
    .o_rs1_val(o_rs1_val), .o_rs2_val(o_rs2_val), .o_imm(o_imm), .o_illegal(o_illegal)
  );

  zacore_decode_sb #(.NUM_REGS(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_inst(inst), .i_pc(pc), .o_stall(s16),
    .i_stall(stall_in), .i_invalidate(inval), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd[3:0]),
    .i_wb_data(wb_data), .o_valid(v16), .o_pc(pc16), .o_inst_type(type16),
    .o_opcode(op16), .o_funct3(f3_16), .o_funct7(f7_16), .o_rd(rd16),
    .o_rs1_val(rs1_16), .o_rs2_val(rs2_16), .o_imm(imm16), .o_illegal(ill16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_imm", o_imm, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    valid = 1'b1; inst = 32'h00500093; pc = 32'h100;
    #1 chk("addi_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    chk("addi_valid", 32'(o_valid), 32'd1);
    chk("addi_type", 32'(o_type), 32'd1);
    chk("addi_rd", 32'(o_rd), 32'd1);
    chk("addi_imm", o_imm, 32'd5);
    chk("addi_rs1", o_rs1_val, 32'd0);
    chk("addi_pc", o_pc, 32'h100);
    inst = 32'h00108133; pc = 32'h104;
    #1 chk("raw_stall", 32'(o_stall), 32'd1);
    @(negedge clk);
    chk("raw_noissue", 32'(o_valid), 32'd0);
    chk("raw_stall2", 32'(o_stall), 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    #1 chk("raw_bypass_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    wb_valid = 1'b0;
    chk("add_valid", 32'(o_valid), 32'd1);
    chk("add_type", 32'(o_type), 32'd0);
    chk("add_rd", 32'(o_rd), 32'd2);
    chk("add_rs1", o_rs1_val, 32'd5);
    chk("add_rs2", o_rs2_val, 32'd5);
    chk("add_imm", o_imm, 32'd0);
    inst = 32'h00708193; pc = 32'h108; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", 32'(o_stall), 32'd1);
      @(negedge clk);
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_pc", o_pc, 32'h104);
    end
    stall_in = 1'b0;
    #1 chk("release_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    chk("rel_pc", o_pc, 32'h108);
    chk("rel_rd", 32'(o_rd), 32'd3);
    chk("rel_rs1", o_rs1_val, 32'd5);
    chk("rel_imm", o_imm, 32'd7);
    inst = 32'h00900213; pc = 32'h10C; stall_in = 1'b1;
    #1 chk("inv_pre_stall", 32'(o_stall), 32'd1);
    @(negedge clk);
    chk("inv_held_pc", o_pc, 32'h108);
    inval = 1'b1;
    #1 chk("inv_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    chk("inv_valid", 32'(o_valid), 32'd0);
    inval = 1'b0; stall_in = 1'b0;
    @(negedge clk);
    chk("post_inv_pc", o_pc, 32'h10C);
    chk("post_inv_imm", o_imm, 32'd9);
    inst = 32'h00118193; pc = 32'h110;
    #1 chk("pend3_cleared", 32'(o_stall), 32'd0);
    @(negedge clk);
    chk("x3_pc", o_pc, 32'h110);
    chk("x3_rs1", o_rs1_val, 32'd0);
    inst = 32'hFE532E23; pc = 32'h114;
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    @(negedge clk);
    wb_valid = 1'b0;
    chk("sw_type", 32'(o_type), 32'd2);
    chk("sw_imm", o_imm, 32'hFFFFFFFC);
    chk("sw_rd", 32'(o_rd), 32'd0);
    chk("sw_f3", 32'(o_funct3), 32'd2);
    chk("sw_op", 32'(o_opcode), 32'h23);
    chk("sw_rs2", o_rs2_val, 32'h55);
    inst = 32'hFF9FF06F; pc = 32'h118;
    @(negedge clk);
    chk("jal_type", 32'(o_type), 32'd5);
    chk("jal_imm", o_imm, 32'hFFFFFFF8);
    chk("jal_rd", 32'(o_rd), 32'd0);
    inst = 32'h123453B7; pc = 32'h11C;
    @(negedge clk);
    chk("lui_type", 32'(o_type), 32'd4);
    chk("lui_imm", o_imm, 32'h12345000);
    chk("lui_rd", 32'(o_rd), 32'd7);
    inst = 32'h0000007F; pc = 32'h120;
    @(negedge clk);
    chk("ill_valid", 32'(o_valid), 32'd1);
    chk("ill_flag", 32'(o_illegal), 32'd1);
    chk("ill_type", 32'(o_type), 32'd0);
    chk("ill_rd", 32'(o_rd), 32'd0);
    inst = 32'h123453B7; pc = 32'h124; stall_in = 1'b1;
    #1 chk("pre_rst_stall", 32'(o_stall), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_ill", 32'(o_illegal), 32'd0);
    chk("arst_pc", o_pc, 32'd0);
    chk("arst_imm", o_imm, 32'd0);
    chk("arst_stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; stall_in = 1'b0;
    inst = 32'h002088B3; pc = 32'h200;
    @(negedge clk);
    chk("e_ill16", 32'(ill16), 32'd1);
    chk("e_rd16", 32'(rd16), 32'd0);
    chk("e_valid16", 32'(v16), 32'd1);
    chk("e_ill32", 32'(o_illegal), 32'd0);
    chk("e_rd32", 32'(o_rd), 32'd17);
    inst = 32'h00000093; pc = 32'h204;
    #1 chk("e_nopend16", 32'(s16), 32'd0);
    @(negedge clk);
    chk("e_next16", 32'(v16), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
